// File: rtl/fb_pkg.sv
// Shared types and widths for the framebuffer pixel writer and its FIFO.
package fb_pkg;

    localparam int COLOR_W   = 12;
    localparam int COORD_W   = 8;
    localparam int FB_ADDR_W = 16;
    localparam int LEVEL_W   = 7;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

    // Framebuffer is row-major: the row forms the upper address byte.
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input pixel_t p);
        return {p.y, p.x};
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead FIFO of pixel_t; the head entry is visible without a pop.
module pix_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  pixel_t             i_data,
    output pixel_t             o_head,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers pixel requests and writes them to the framebuffer as grants allow.
// Optional statistics counters are enabled with the FB_STATS_EN macro.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DEDUP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    input  logic [COORD_W-1:0]   pix_x,
    input  logic [COORD_W-1:0]   pix_y,
    input  logic [COLOR_W-1:0]   pix_color,
    output logic                 pix_ready,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOR_W-1:0]   mem_data,
    input  logic                 mem_grant,
    input  logic                 ovf_clr,
    output logic                 overflow,
    output logic [LEVEL_W-1:0]   fifo_level,
    output logic                 idle
`ifdef FB_STATS_EN
    ,
    output logic [15:0]          wr_count,
    output logic [15:0]          drop_count
`endif
);

    pixel_t             w_pix;
    pixel_t             w_head;
    logic [LEVEL_W-1:0] w_level;
    logic               w_empty;
    logic               w_accept;
    logic               w_dup;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;

    wr_state_t          r_state;
    wr_state_t          w_next_state;
    pixel_t             r_last;
    logic               r_last_valid;
    logic               r_overflow;

    assign w_pix.x     = pix_x;
    assign w_pix.y     = pix_y;
    assign w_pix.color = pix_color;

    assign pix_ready = (w_level != LEVEL_W'(FIFO_DEPTH));
    assign w_accept  = pix_valid & pix_ready;
    assign w_dup     = (DEDUP != 0) & r_last_valid & (w_pix == r_last);
    assign w_push    = w_accept & ~w_dup;
    assign w_pop     = mem_we & mem_grant;
    assign w_ovf_set = pix_valid & ~pix_ready;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pix),
        .o_head  (w_head),
        .o_level (w_level),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Entering WRITE on the push itself keeps first-write latency at one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty || w_push) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_pop && (w_level == LEVEL_W'(1)) && !w_push) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (r_state == ST_WRITE) begin
            mem_we   = 1'b1;
            mem_addr = pix_addr(w_head);
            mem_data = w_head.color;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_last       <= '0;
            r_last_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_last       <= w_pix;
                r_last_valid <= 1'b1;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign overflow   = r_overflow;
    assign fifo_level = w_level;
    assign idle       = (r_state == ST_IDLE) & (w_level == '0);

`ifdef FB_STATS_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_drop_count;
    logic        w_drop;

    assign w_drop = w_ovf_set | (w_accept & w_dup);

    // Write count wraps; drop count saturates so a flood of drops stays visible.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign wr_count   = r_wr_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench: instance 0 has dedup on, instance 1 has it off; both are
// compared every cycle against a queue-based model of the writer.
module tb_fb_pixel_writer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [11:0] pix_color;
    logic        mem_grant;
    logic        ovf_clr;

    logic        ready [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [11:0] data  [2];
    logic        ovf   [2];
    logic [6:0]  level [2];
    logic        idleO [2];
`ifdef FB_STATS_EN
    logic [15:0] wrCount   [2];
    logic [15:0] dropCount [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_pixel_writer #(.FIFO_DEPTH(8), .DEDUP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .pix_ready(ready[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_data(data[0]), .mem_grant(mem_grant), .ovf_clr(ovf_clr), .overflow(ovf[0]),
        .fifo_level(level[0]), .idle(idleO[0])
`ifdef FB_STATS_EN
        , .wr_count(wrCount[0]), .drop_count(dropCount[0])
`endif
    );

    fb_pixel_writer #(.FIFO_DEPTH(8), .DEDUP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .pix_ready(ready[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_data(data[1]), .mem_grant(mem_grant), .ovf_clr(ovf_clr), .overflow(ovf[1]),
        .fifo_level(level[1]), .idle(idleO[1])
`ifdef FB_STATS_EN
        , .wr_count(wrCount[1]), .drop_count(dropCount[1])
`endif
    );

    // Model state: pending pixels as {x,y,color}, last pushed pixel, sticky overflow.
    logic [27:0] mq [2][$];
    logic        mLastValid [2];
    logic [27:0] mLast [2];
    logic        mOvf [2];

    typedef struct {
        logic        v;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
        logic        g;
        logic        clr;
        logic        we;
        logic [15:0] addr;
        logic [11:0] data;
        logic [6:0]  level;
        logic        ready;
        logic        ovf;
        logic        idle;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mLastValid[i] = 1'b0;
            mLast[i]      = '0;
            mOvf[i]       = 1'b0;
        end
    endtask

    task automatic modelStep(input logic v, input logic [27:0] p, input logic g, input logic c);
        for (int i = 0; i < 2; i++) begin
            int sz;
            bit full;
            bit dup;
            sz   = mq[i].size();
            full = (sz == 8);
            dup  = (i == 0) && mLastValid[i] && (mLast[i] == p);
            if (sz > 0 && g) void'(mq[i].pop_front());
            if (v && !full && !dup) begin
                mq[i].push_back(p);
                mLast[i]      = p;
                mLastValid[i] = 1'b1;
            end
            if (v && full) mOvf[i] = 1'b1;
            else if (c) mOvf[i] = 1'b0;
        end
    endtask

    task automatic checkModel();
        for (int i = 0; i < 2; i++) begin
            int          sz;
            logic [27:0] h;
            logic        eWe;
            sz  = mq[i].size();
            h   = (sz > 0) ? mq[i][0] : 28'd0;
            eWe = (sz > 0);
            checkOutput($sformatf("we%0d", i), 32'(we[i]), 32'(eWe));
            checkOutput($sformatf("addr%0d", i), 32'(addr[i]), eWe ? 32'({h[19:12], h[27:20]}) : 32'd0);
            checkOutput($sformatf("data%0d", i), 32'(data[i]), eWe ? 32'(h[11:0]) : 32'd0);
            checkOutput($sformatf("level%0d", i), 32'(level[i]), 32'(sz));
            checkOutput($sformatf("ready%0d", i), 32'(ready[i]), 32'(sz != 8));
            checkOutput($sformatf("idle%0d", i), 32'(idleO[i]), 32'(sz == 0));
            checkOutput($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(mOvf[i]));
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [7:0] y,
                                 input logic [11:0] c, input logic g, input logic clr);
        pix_valid = v;
        pix_x     = v ? x : 8'hxx;
        pix_y     = v ? y : 8'hxx;
        pix_color = v ? c : 12'hxxx;
        mem_grant = g;
        ovf_clr   = clr;
        @(posedge clk);
        modelStep(v, {x, y, c}, g, clr);
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        pix_valid = 1'b0;
        mem_grant = 1'b0;
        ovf_clr   = 1'b0;
        rst_n     = 1'b1;
        #1;
        checkOutput("rst_we", 32'(we[0]), 32'd0);
        checkOutput("rst_level", 32'(level[0]), 32'd0);
        checkOutput("rst_idle", 32'(idleO[0]), 32'd1);
        checkOutput("rst_ready", 32'(ready[0]), 32'd1);
        checkOutput("rst_ovf", 32'(ovf[0]), 32'd0);
        checkOutput("rst_addr", 32'(addr[0]), 32'd0);
        checkOutput("rst_data", 32'(data[0]), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int maxLvl;
        logic g;

        vecs[0] = '{1, 8'h12, 8'h34, 12'hF00, 1, 0, 1, 16'h3412, 12'hF00, 1, 1, 0, 0};
        vecs[1] = '{0, 8'h00, 8'h00, 12'h000, 1, 0, 0, 16'h0000, 12'h000, 0, 1, 0, 1};
        vecs[2] = '{0, 8'h00, 8'h00, 12'h000, 1, 0, 0, 16'h0000, 12'h000, 0, 1, 0, 1};
        vecs[3] = '{1, 8'h01, 8'h02, 12'h0AB, 0, 0, 1, 16'h0201, 12'h0AB, 1, 1, 0, 0};
        vecs[4] = '{1, 8'h01, 8'h02, 12'h0AB, 0, 0, 1, 16'h0201, 12'h0AB, 1, 1, 0, 0};
        vecs[5] = '{1, 8'h01, 8'h02, 12'h0AB, 0, 0, 1, 16'h0201, 12'h0AB, 1, 1, 0, 0};
        vecs[6] = '{1, 8'h03, 8'h04, 12'h123, 0, 0, 1, 16'h0201, 12'h0AB, 2, 1, 0, 0};
        vecs[7] = '{0, 8'h00, 8'h00, 12'h000, 1, 0, 1, 16'h0403, 12'h123, 1, 1, 0, 0};
        vecs[8] = '{0, 8'h00, 8'h00, 12'h000, 1, 0, 0, 16'h0000, 12'h000, 0, 1, 0, 1};
        vecs[9] = '{1, 8'h03, 8'h04, 12'h123, 1, 0, 0, 16'h0000, 12'h000, 0, 1, 0, 1};

        rst_n = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        mem_grant = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        doReset();

        // Directed table: single pixel latency, then dedup across a drained FIFO.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].g, vecs[i].clr);
            checkOutput($sformatf("tbl%0d_we", i), 32'(we[0]), 32'(vecs[i].we));
            checkOutput($sformatf("tbl%0d_addr", i), 32'(addr[0]), 32'(vecs[i].addr));
            checkOutput($sformatf("tbl%0d_data", i), 32'(data[0]), 32'(vecs[i].data));
            checkOutput($sformatf("tbl%0d_level", i), 32'(level[0]), 32'(vecs[i].level));
            checkOutput($sformatf("tbl%0d_ready", i), 32'(ready[0]), 32'(vecs[i].ready));
            checkOutput($sformatf("tbl%0d_ovf", i), 32'(ovf[0]), 32'(vecs[i].ovf));
            checkOutput($sformatf("tbl%0d_idle", i), 32'(idleO[0]), 32'(vecs[i].idle));
        end

        // Same pixel three times then a new one, continuous grant.
        doReset();
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) applyStimulus(1, 8'h55, 8'h66, 12'h777, 1, 0);
            else if (i == 3) applyStimulus(1, 8'h56, 8'h66, 12'h777, 1, 0);
            else applyStimulus(0, 0, 0, 0, 1, 0);
            cnt0 += int'(we[0]);
            cnt1 += int'(we[1]);
        end
        checkOutput("dedup_writes", 32'(cnt0), 32'd2);
        checkOutput("nodedup_writes", 32'(cnt1), 32'd4);

        // Eight distinct pixels back-to-back under continuous grant.
        doReset();
        cnt0 = 0; maxLvl = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) applyStimulus(1, 8'(i), 8'(i + 16), 12'(i * 3), 1, 0);
            else applyStimulus(0, 0, 0, 0, 1, 0);
            cnt0 += int'(we[0]);
            if (int'(level[0]) > maxLvl) maxLvl = int'(level[0]);
        end
        checkOutput("burst_writes", 32'(cnt0), 32'd8);
        checkOutput("burst_maxlevel", 32'(maxLvl), 32'd1);

        // Fill with grant low, overflow on the ninth, pop during full does not admit.
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1, 8'(i + 1), 8'h20, 12'h0F0, 0, 0);
        checkOutput("full_level", 32'(level[0]), 32'd8);
        checkOutput("full_ready", 32'(ready[0]), 32'd0);
        checkOutput("full_ovf", 32'(ovf[0]), 32'd1);
        applyStimulus(1, 8'hAA, 8'hBB, 12'hCCC, 1, 1);
        checkOutput("setclr_ovf", 32'(ovf[0]), 32'd1);
        checkOutput("popfull_level", 32'(level[0]), 32'd7);
        cnt0 = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            cnt0 += int'(we[0]);
        end
        checkOutput("drain_writes", 32'(cnt0), 32'd6);
        checkOutput("drain_idle", 32'(idleO[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("clr_ovf", 32'(ovf[0]), 32'd0);

        // Toggling grant keeps the head stable, then reset in the middle of a burst.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(i + 40), 8'h07, 12'(i + 9), 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1'(i % 2), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i + 60), 8'h09, 12'h3C3, 0, 0);
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);

        // Random traffic with phases of mostly-granted and mostly-blocked memory.
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ((i / 50) % 2 == 0) g = ($urandom_range(0, 3) == 0);
            else g = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 1)),
                          12'($urandom_range(0, 1)), g, $urandom_range(0, 15) == 0);
        end

`ifdef FB_STATS_EN
        doReset();
        for (int i = 0; i < 70000; i++) begin
            pix_valid = 1'b1;
            pix_x     = i[7:0];
            pix_y     = i[15:8];
            pix_color = 12'h5A5;
            mem_grant = 1'b1;
            ovf_clr   = 1'b0;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("wr_count0", 32'(wrCount[0]), 32'd4464);
        checkOutput("wr_count1", 32'(wrCount[1]), 32'd4464);
        checkOutput("drop_count0", 32'(dropCount[0]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
